zap_predecode_branch: RTL and testbench

- Pre-decode stage directly downstream of the branch predictor; consumes its registered instruction/PC/prediction bundle.
- Resolves ARM B/BL targets one stage early and redirects fetch when the branch is unconditional or predicted taken.
- Forwards the bundle, with the final taken flag, to the main decoder.
- Holds its redirect request until the upstream stage can accept it.

---
 rtl/zap_predecode_branch.sv | 104 ++++++++++
 tb/tb_zap_predecode_branch.sv | 110 +++++++++++
 2 files changed

// File: rtl/zap_predecode_branch.sv
// zap_predecode_branch: early B/BL target resolution and fetch redirect ahead of the main decoder
module zap_predecode_branch (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_decode,
  input  logic        i_cpsr_t,
  input  logic [31:0] i_inst,
  input  logic        i_val,
  input  logic        i_abt,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus_8,
  input  logic        i_taken,
  output logic [31:0] o_inst_ff,
  output logic        o_val_ff,
  output logic        o_abt_ff,
  output logic [31:0] o_pc_ff,
  output logic [31:0] o_pc_plus_8_ff,
  output logic        o_taken_ff,
  output logic        o_clear_from_decode,
  output logic [31:0] o_pc_from_decode
);
  typedef enum logic {IDLE, REDIRECT} state_t;
  state_t state, n_state;
  logic [31:0] n_inst, n_pc, n_pc_plus_8, n_pc_from, target;
  logic        n_val, n_abt, n_taken, n_clr;
  logic        is_b, is_al, redirect, stall, flush;
  assign stall    = i_data_stall | i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
  assign flush    = i_clear_from_writeback | (!i_data_stall & i_clear_from_alu);
  assign is_b     = i_val & !i_abt & !i_cpsr_t & (i_inst[27:25] == 3'b101) & (i_inst[31:28] != 4'b1111);
  assign is_al    = is_b & (i_inst[31:28] == 4'b1110);
  assign redirect = is_al | (is_b & i_taken);
  assign target   = i_pc_plus_8 + {{6{i_inst[23]}}, i_inst[23:0], 2'b00};
  // next-state and next-output selection; flush beats stall beats advance
  always_comb begin
    n_state     = state;
    n_inst      = o_inst_ff;
    n_val       = o_val_ff;
    n_abt       = o_abt_ff;
    n_pc        = o_pc_ff;
    n_pc_plus_8 = o_pc_plus_8_ff;
    n_taken     = o_taken_ff;
    n_clr       = o_clear_from_decode;
    n_pc_from   = o_pc_from_decode;
    if (flush) begin
      n_state     = IDLE;
      n_inst      = '0;
      n_val       = 1'b0;
      n_abt       = 1'b0;
      n_pc        = '0;
      n_pc_plus_8 = 32'd8;
      n_taken     = 1'b0;
      n_clr       = 1'b0;
      n_pc_from   = '0;
    end else if (!stall) begin
      n_pc        = i_pc;
      n_pc_plus_8 = i_pc_plus_8;
      if (state == IDLE) begin
        n_inst    = i_inst;
        n_val     = i_val;
        n_abt     = i_abt;
        n_taken   = i_taken | is_al;
        n_clr     = redirect;
        n_pc_from = redirect ? target : o_pc_from_decode;
        n_state   = redirect ? REDIRECT : IDLE;
      end else begin
        n_inst  = '0;
        n_val   = 1'b0;
        n_abt   = 1'b0;
        n_taken = 1'b0;
        n_clr   = 1'b0;
        n_state = IDLE;
      end
    end
  end
  // output and state registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state               <= IDLE;
      o_inst_ff           <= '0;
      o_val_ff            <= 1'b0;
      o_abt_ff            <= 1'b0;
      o_pc_ff             <= '0;
      o_pc_plus_8_ff      <= 32'd8;
      o_taken_ff          <= 1'b0;
      o_clear_from_decode <= 1'b0;
      o_pc_from_decode    <= '0;
    end else begin
      state               <= n_state;
      o_inst_ff           <= n_inst;
      o_val_ff            <= n_val;
      o_abt_ff            <= n_abt;
      o_pc_ff             <= n_pc;
      o_pc_plus_8_ff      <= n_pc_plus_8;
      o_taken_ff          <= n_taken;
      o_clear_from_decode <= n_clr;
      o_pc_from_decode    <= n_pc_from;
    end
  end
endmodule

// File: tb/tb_zap_predecode_branch.sv
// tb_zap_predecode_branch: directed checks of redirect, stall hold, flush and gating
module tb_zap_predecode_branch;
  logic        clk = 0, rst, clr_wb, dstall, clr_alu, st_sh, st_is, st_de, cpsr_t;
  logic [31:0] inst, pc, pc8;
  logic        val, abt, taken;
  logic [31:0] inst_ff, pc_ff, pc8_ff, pc_from;
  logic        val_ff, abt_ff, taken_ff, clr;
  int          total = 0, passed = 0;
  zap_predecode_branch dut (
    .i_clk(clk), .i_reset(rst), .i_clear_from_writeback(clr_wb), .i_data_stall(dstall),
    .i_clear_from_alu(clr_alu), .i_stall_from_shifter(st_sh), .i_stall_from_issue(st_is),
    .i_stall_from_decode(st_de), .i_cpsr_t(cpsr_t), .i_inst(inst), .i_val(val), .i_abt(abt),
    .i_pc(pc), .i_pc_plus_8(pc8), .i_taken(taken), .o_inst_ff(inst_ff), .o_val_ff(val_ff),
    .o_abt_ff(abt_ff), .o_pc_ff(pc_ff), .o_pc_plus_8_ff(pc8_ff), .o_taken_ff(taken_ff),
    .o_clear_from_decode(clr), .o_pc_from_decode(pc_from)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] i, input logic [31:0] p8, input logic t);
    inst = i; pc = p8 - 32'd8; pc8 = p8; taken = t; val = 1;
  endtask
  initial begin
    rst = 1; clr_wb = 0; dstall = 0; clr_alu = 0; st_sh = 0; st_is = 0; st_de = 0; cpsr_t = 0;
    inst = 0; pc = 0; pc8 = 0; val = 0; abt = 0; taken = 0;
    tick(); tick();
    chk("rst_inst", inst_ff, 0);
    chk("rst_val", {31'd0, val_ff}, 0);
    chk("rst_abt", {31'd0, abt_ff}, 0);
    chk("rst_pc", pc_ff, 0);
    chk("rst_pc8", pc8_ff, 32'd8);
    chk("rst_taken", {31'd0, taken_ff}, 0);
    chk("rst_clr", {31'd0, clr}, 0);
    chk("rst_pcfrom", pc_from, 0);
    rst = 0;
    drive(32'hEA000002, 32'h108, 0); tick();
    chk("al_val", {31'd0, val_ff}, 1);
    chk("al_inst", inst_ff, 32'hEA000002);
    chk("al_taken", {31'd0, taken_ff}, 1);
    chk("al_clr", {31'd0, clr}, 1);
    chk("al_target", pc_from, 32'h110);
    chk("al_pc", pc_ff, 32'h100);
    drive(32'hE1A00000, 32'h10C, 0); tick();
    chk("al_discard_val", {31'd0, val_ff}, 0);
    chk("al_discard_inst", inst_ff, 0);
    chk("al_discard_clr", {31'd0, clr}, 0);
    drive(32'h0AFFFFFE, 32'h208, 0); tick();
    chk("cnp_val", {31'd0, val_ff}, 1);
    chk("cnp_taken", {31'd0, taken_ff}, 0);
    chk("cnp_clr", {31'd0, clr}, 0);
    chk("cnp_pcfrom_kept", pc_from, 32'h110);
    drive(32'h0AFFFFFE, 32'h208, 1); tick();
    chk("cp_taken", {31'd0, taken_ff}, 1);
    chk("cp_clr", {31'd0, clr}, 1);
    chk("cp_target", pc_from, 32'h200);
    drive(32'hE1A00000, 32'h20C, 0); tick();
    chk("cp_discard_clr", {31'd0, clr}, 0);
    drive(32'hEA000010, 32'h1008, 0); tick();
    chk("st_clr0", {31'd0, clr}, 1);
    chk("st_target", pc_from, 32'h1048);
    drive(32'hE1A00000, 32'h100C, 1); dstall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_hold_clr", {31'd0, clr}, 1);
      chk("st_hold_inst", inst_ff, 32'hEA000010);
      chk("st_hold_val", {31'd0, val_ff}, 1);
      chk("st_hold_pcfrom", pc_from, 32'h1048);
    end
    dstall = 0; tick();
    chk("st_discard_clr", {31'd0, clr}, 0);
    chk("st_discard_val", {31'd0, val_ff}, 0);
    chk("st_discard_inst", inst_ff, 0);
    drive(32'hEA000002, 32'h308, 0); tick();
    chk("alu_pre_clr", {31'd0, clr}, 1);
    clr_alu = 1; tick(); clr_alu = 0;
    chk("alu_clr", {31'd0, clr}, 0);
    chk("alu_val", {31'd0, val_ff}, 0);
    chk("alu_pc8", pc8_ff, 32'd8);
    chk("alu_pcfrom", pc_from, 0);
    chk("alu_taken", {31'd0, taken_ff}, 0);
    drive(32'hE1A00000, 32'h408, 1); tick();
    chk("alu_idle_val", {31'd0, val_ff}, 1);
    chk("nb_taken_pass", {31'd0, taken_ff}, 1);
    chk("nb_clr", {31'd0, clr}, 0);
    drive(32'hEA000004, 32'hFFFFFFF8, 0); tick();
    chk("wrap_target", pc_from, 32'h8);
    chk("wrap_clr", {31'd0, clr}, 1);
    drive(32'hE1A00000, 32'h0, 0); tick();
    chk("wrap_discard_clr", {31'd0, clr}, 0);
    drive(32'hEA000002, 32'h508, 0); abt = 1; tick(); abt = 0;
    chk("abt_clr", {31'd0, clr}, 0);
    chk("abt_ff", {31'd0, abt_ff}, 1);
    chk("abt_taken", {31'd0, taken_ff}, 0);
    drive(32'hEA000002, 32'h608, 0); cpsr_t = 1; tick(); cpsr_t = 0;
    chk("thumb_clr", {31'd0, clr}, 0);
    drive(32'hFA000002, 32'h708, 0); tick();
    chk("nv_clr", {31'd0, clr}, 0);
    chk("nv_val", {31'd0, val_ff}, 1);
    chk("nv_taken", {31'd0, taken_ff}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
